// File: rtl/fp_conv_pkg.sv
// Shared constants, classification enum and stage-1 payload for the
// binary64 -> binary32 narrowing converter.
package fp_conv_pkg;

    localparam int F64_EXP_W  = 11;
    localparam int F64_MAN_W  = 52;
    localparam int F32_EXP_W  = 8;
    localparam int F32_MAN_W  = 23;
    localparam int BIAS_DELTA = 896;

    localparam int FLAG_INX = 0;
    localparam int FLAG_UF  = 1;
    localparam int FLAG_OV  = 2;
    localparam int FLAG_INV = 3;

    typedef enum logic [2:0] {
        CLS_ZERO,
        CLS_SUB64,
        CLS_NORM,
        CLS_INF,
        CLS_QNAN,
        CLS_SNAN
    } fp_class_e;

    typedef struct packed {
        logic                        sign;
        fp_class_e                   cls;
        logic signed [F64_EXP_W:0]   exp;
        logic [F64_MAN_W:0]          sig;
    } s1_payload_t;

    function automatic fp_class_e classify(input logic [F64_EXP_W-1:0] e,
                                           input logic [F64_MAN_W-1:0] m);
        if (e == '0)
            return (m == '0) ? CLS_ZERO : CLS_SUB64;
        if (e == '1) begin
            if (m == '0)
                return CLS_INF;
            return m[F64_MAN_W-1] ? CLS_QNAN : CLS_SNAN;
        end
        return CLS_NORM;
    endfunction

endpackage

// File: rtl/fp_round_rne.sv
// Combinational round-to-nearest-even pack of a finite normal binary64
// value (rebiased exponent, 53-bit significand) into binary32 with flags.
module fp_round_rne
    import fp_conv_pkg::*;
(
    input  logic               sign,
    input  logic signed [11:0] exp,
    input  logic [52:0]        sig,
    input  logic               flush,
    output logic [31:0]        bits,
    output logic [3:0]         flags
);

    function automatic logic rne_up(input logic lsb, input logic guard, input logic sticky);
        return guard && (sticky || lsb);
    endfunction

    // Distance into the subnormal range; beyond 26 every bit is below guard anyway.
    function automatic logic [4:0] sat_shamt(input logic signed [11:0] e);
        logic signed [12:0] s;
        s = 13'sd1 - 13'(e);
        return (s > 13'sd26) ? 5'd26 : s[4:0];
    endfunction

    logic [4:0]           shamt;
    logic [51:0]          sh;
    logic                 lost;
    logic                 guard;
    logic                 sticky;
    logic                 up;
    logic                 inexact;
    logic [F32_MAN_W:0]   sum;
    logic [F32_EXP_W:0]   exp_inc;

    always_comb begin
        bits    = '0;
        flags   = '0;
        shamt   = '0;
        sh      = '0;
        lost    = 1'b0;
        guard   = 1'b0;
        sticky  = 1'b0;
        up      = 1'b0;
        inexact = 1'b0;
        sum     = '0;
        exp_inc = '0;
        if (exp >= 12'sd255) begin
            bits            = {sign, {F32_EXP_W{1'b1}}, {F32_MAN_W{1'b0}}};
            flags[FLAG_OV]  = 1'b1;
            flags[FLAG_INX] = 1'b1;
        end else if (exp >= 12'sd1) begin
            guard   = sig[28];
            sticky  = |sig[27:0];
            up      = rne_up(sig[29], guard, sticky);
            sum     = {1'b0, sig[51:29]} + {{F32_MAN_W{1'b0}}, up};
            exp_inc = {1'b0, exp[7:0]} + {{F32_EXP_W{1'b0}}, sum[F32_MAN_W]};
            inexact = guard || sticky;
            if (exp_inc == 9'd255) begin
                bits            = {sign, {F32_EXP_W{1'b1}}, {F32_MAN_W{1'b0}}};
                flags[FLAG_OV]  = 1'b1;
                flags[FLAG_INX] = 1'b1;
            end else begin
                bits            = {sign, exp_inc[7:0], sum[F32_MAN_W-1:0]};
                flags[FLAG_INX] = inexact;
            end
        end else begin
            shamt   = sat_shamt(exp);
            sh      = 52'(sig >> shamt);
            lost    = |(sig & ((53'd1 << shamt) - 53'd1));
            guard   = sh[28];
            sticky  = (|sh[27:0]) || lost;
            up      = rne_up(sh[29], guard, sticky);
            sum     = {1'b0, sh[51:29]} + {{F32_MAN_W{1'b0}}, up};
            inexact = guard || sticky;
            // A carry out of the subnormal field lands exactly on the minimum normal.
            if (flush && !sum[F32_MAN_W] && (sum[F32_MAN_W-1:0] != '0)) begin
                bits            = {sign, 31'd0};
                flags[FLAG_UF]  = 1'b1;
                flags[FLAG_INX] = 1'b1;
            end else begin
                bits            = {sign, 7'd0, sum[F32_MAN_W], sum[F32_MAN_W-1:0]};
                flags[FLAG_INX] = inexact;
                flags[FLAG_UF]  = inexact && !sum[F32_MAN_W];
            end
        end
    end

endmodule

// File: rtl/fp64_to_fp32_narrow.sv
// Two-stage stall-all pipeline narrowing binary64 encodings to binary32
// with round-to-nearest-even and per-word exception flags.
module fp64_to_fp32_narrow
    import fp_conv_pkg::*;
#(
    parameter bit FLUSH_SUBNORMAL = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_bits,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_bits,
    output logic [3:0]  out_flags
);

    s1_payload_t pay_in;
    s1_payload_t pay_p1_d, pay_p1_q;
    logic        vld_p1_d, vld_p1_q;
    logic        vld_p2_d, vld_p2_q;
    logic [31:0] bits_p2_d, bits_p2_q;
    logic [3:0]  flags_p2_d, flags_p2_q;
    logic [31:0] rnd_bits, res_bits;
    logic [3:0]  rnd_flags, res_flags;
    logic        advance;

    // Stage 1: unpack and classify
    always_comb begin
        pay_in.sign = in_bits[63];
        pay_in.cls  = classify(in_bits[62:52], in_bits[51:0]);
        pay_in.exp  = $signed({1'b0, in_bits[62:52]}) - $signed(12'(BIAS_DELTA));
        pay_in.sig  = {1'b1, in_bits[51:0]};
    end

    // Stage 2: round and pack
    fp_round_rne u_round (
        .sign  (pay_p1_q.sign),
        .exp   (pay_p1_q.exp),
        .sig   (pay_p1_q.sig),
        .flush (FLUSH_SUBNORMAL),
        .bits  (rnd_bits),
        .flags (rnd_flags)
    );

    always_comb begin
        res_bits  = '0;
        res_flags = '0;
        unique case (pay_p1_q.cls)
            CLS_ZERO: res_bits = {pay_p1_q.sign, 31'd0};
            CLS_SUB64: begin
                res_bits            = {pay_p1_q.sign, 31'd0};
                res_flags[FLAG_UF]  = 1'b1;
                res_flags[FLAG_INX] = 1'b1;
            end
            CLS_NORM: begin
                res_bits  = rnd_bits;
                res_flags = rnd_flags;
            end
            CLS_INF: res_bits = {pay_p1_q.sign, 8'hFF, 23'd0};
            CLS_QNAN, CLS_SNAN: begin
                res_bits            = {pay_p1_q.sign, 8'hFF, 1'b1, pay_p1_q.sig[50:29]};
                res_flags[FLAG_INV] = (pay_p1_q.cls == CLS_SNAN);
            end
            default: res_bits = '0;
        endcase
    end

    always_comb begin
        advance    = !vld_p2_q || out_ready;
        vld_p1_d   = vld_p1_q;
        pay_p1_d   = pay_p1_q;
        vld_p2_d   = vld_p2_q;
        bits_p2_d  = bits_p2_q;
        flags_p2_d = flags_p2_q;
        if (advance) begin
            vld_p1_d = in_valid;
            vld_p2_d = vld_p1_q;
            if (in_valid)
                pay_p1_d = pay_in;
            if (vld_p1_q) begin
                bits_p2_d  = res_bits;
                flags_p2_d = res_flags;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1_q   <= 1'b0;
            vld_p2_q   <= 1'b0;
            bits_p2_q  <= '0;
            flags_p2_q <= '0;
        end else begin
            vld_p1_q   <= vld_p1_d;
            vld_p2_q   <= vld_p2_d;
            bits_p2_q  <= bits_p2_d;
            flags_p2_q <= flags_p2_d;
        end
    end

    always_ff @(posedge clk) begin
        pay_p1_q <= pay_p1_d;
    end

    assign in_ready  = advance;
    assign out_valid = vld_p2_q;
    assign out_bits  = bits_p2_q;
    assign out_flags = flags_p2_q;

endmodule

// File: tb/tb_fp64_to_fp32_narrow.sv
// Bench for fp64_to_fp32_narrow: directed corner values, randomized stream with
// backpressure, stall hold behaviour and mid-stream reset.
module tb_fp64_to_fp32_narrow;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready, fl_in_ready;
    logic [63:0] in_bits;
    logic        out_valid, fl_out_valid;
    logic        out_ready;
    logic [31:0] out_bits, fl_out_bits;
    logic [3:0]  out_flags, fl_out_flags;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fp64_to_fp32_narrow #(.FLUSH_SUBNORMAL(1'b0)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_bits(in_bits),
        .out_valid(out_valid), .out_ready(out_ready), .out_bits(out_bits), .out_flags(out_flags)
    );

    fp64_to_fp32_narrow #(.FLUSH_SUBNORMAL(1'b1)) dut_fl (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(fl_in_ready), .in_bits(in_bits),
        .out_valid(fl_out_valid), .out_ready(out_ready), .out_bits(fl_out_bits), .out_flags(fl_out_flags)
    );

    // Reference: exact value sig * 2^(E-52), re-quantised to the binary32 grid
    // (LSB weight 2^(E-23) for normals, 2^-149 below) with integer remainder rounding.
    function automatic void ref_model(input logic [63:0] x, input bit flush,
                                      output logic [31:0] r, output logic [3:0] f);
        logic              s;
        int                e, ue, q, d, be;
        logic [51:0]       m;
        longint unsigned   sig, n, rem, half;
        bit                inexact;
        s = x[63];
        e = int'(x[62:52]);
        m = x[51:0];
        r = '0;
        f = '0;
        if (e == 2047) begin
            if (m == '0) r = {s, 8'hFF, 23'h0};
            else begin
                r = {s, 8'hFF, 1'b1, m[50:29]};
                f[3] = !m[51];
            end
        end else if (e == 0) begin
            r = {s, 31'h0};
            if (m != '0) f = 4'b0011;
        end else begin
            sig = (64'd1 << 52) | 64'(m);
            ue  = e - 1023;
            q   = (ue < -126) ? -149 : ue - 23;
            d   = q - (ue - 52);
            if (d >= 60) begin
                n = 0;
                inexact = 1'b1;
            end else begin
                n       = sig >> d;
                rem     = sig & ((64'd1 << d) - 64'd1);
                half    = 64'd1 << (d - 1);
                inexact = (rem != 0);
                if (rem > half || (rem == half && n[0])) n = n + 1;
            end
            if (n >= (64'd1 << 24)) begin
                n = n >> 1;
                q = q + 1;
            end
            if (n >= (64'd1 << 23)) begin
                be = q + 23 + 127;
                if (be >= 255) begin
                    r = {s, 8'hFF, 23'h0};
                    f = 4'b0101;
                end else begin
                    r = {s, 8'(be), 23'(n - (64'd1 << 23))};
                    f[0] = inexact;
                end
            end else if (flush && n != 0) begin
                r = {s, 31'h0};
                f = 4'b0011;
            end else begin
                r = {s, 8'd0, 23'(n)};
                f[0] = inexact;
                f[1] = inexact;
            end
        end
    endfunction

    function automatic logic [63:0] gen_word();
        logic [63:0] w;
        logic [10:0] e;
        int sel;
        w   = {$urandom, $urandom};
        sel = $urandom_range(0, 9);
        case (sel)
            0:       e = 11'd0;
            1:       e = 11'h7FF;
            2, 3:    e = 11'($urandom_range(860, 900));
            4:       e = 11'($urandom_range(1140, 1160));
            default: e = 11'($urandom_range(897, 1150));
        endcase
        w[62:52] = e;
        if ($urandom_range(0, 3) == 0) w[28:0] = {1'b1, 28'h0};
        return w;
    endfunction

    localparam int NDIR = 15;
    localparam logic [63:0] DIR_IN [NDIR] = '{
        64'h3FF0000000000000, 64'h3FF0000010000000, 64'h3FF0000030000000,
        64'h47F0000000000000, 64'hC7F0000000000000, 64'h36A0000000000000,
        64'h3690000000000000, 64'h7FF0000000000001, 64'h7FF8000000000000,
        64'h8000000000000000, 64'hFFF0000000000000, 64'h0000000000000001,
        64'h380FFFFFFFFFFFFF, 64'h47EFFFFFE0000000, 64'h47EFFFFFF0000000};
    localparam logic [31:0] DIR_B [NDIR] = '{
        32'h3F800000, 32'h3F800000, 32'h3F800002, 32'h7F800000, 32'hFF800000,
        32'h00000001, 32'h00000000, 32'h7FC00000, 32'h7FC00000, 32'h80000000,
        32'hFF800000, 32'h00000000, 32'h00800000, 32'h7F7FFFFF, 32'h7F800000};
    localparam logic [3:0] DIR_F [NDIR] = '{
        4'h0, 4'h1, 4'h1, 4'h5, 4'h5, 4'h0, 4'h3, 4'h8, 4'h0, 4'h0,
        4'h0, 4'h3, 4'h1, 4'h0, 4'h5};
    localparam logic [31:0] DIR_FB [NDIR] = '{
        32'h3F800000, 32'h3F800000, 32'h3F800002, 32'h7F800000, 32'hFF800000,
        32'h00000000, 32'h00000000, 32'h7FC00000, 32'h7FC00000, 32'h80000000,
        32'hFF800000, 32'h00000000, 32'h00800000, 32'h7F7FFFFF, 32'h7F800000};
    localparam logic [3:0] DIR_FF [NDIR] = '{
        4'h0, 4'h1, 4'h1, 4'h5, 4'h5, 4'h3, 4'h3, 4'h8, 4'h0, 4'h0,
        4'h0, 4'h3, 4'h1, 4'h0, 4'h5};

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_bits = '0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0 || out_bits !== 32'h0 || out_flags !== 4'h0) begin
            n_bad++;
            $display("FAIL reset_state: valid=%0b bits=%h flags=%h, required 0/00000000/0", out_valid, out_bits, out_flags);
        end
        rst = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_in_ready: got %0b, required 1", in_ready);
        end
        out_ready = 1'b1;
    endtask

    task automatic test_directed();
        for (int i = 0; i < NDIR; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_bits = DIR_IN[i]; out_ready = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            n_cmp++;
            if (out_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL dir_latency_early[%0d]: out_valid=%0b one cycle after accept, required 0", i, out_valid);
            end
            @(negedge clk);
            n_cmp++;
            if (out_valid !== 1'b1 || out_bits !== DIR_B[i] || out_flags !== DIR_F[i]) begin
                n_bad++;
                $display("FAIL dir[%0d] in=%h: valid=%0b bits=%h flags=%h, required 1 bits=%h flags=%h",
                         i, DIR_IN[i], out_valid, out_bits, out_flags, DIR_B[i], DIR_F[i]);
            end
            n_cmp++;
            if (fl_out_valid !== 1'b1 || fl_out_bits !== DIR_FB[i] || fl_out_flags !== DIR_FF[i]) begin
                n_bad++;
                $display("FAIL dir_flush[%0d] in=%h: valid=%0b bits=%h flags=%h, required 1 bits=%h flags=%h",
                         i, DIR_IN[i], fl_out_valid, fl_out_bits, fl_out_flags, DIR_FB[i], DIR_FF[i]);
            end
        end
    endtask

    task automatic test_random_stream(input int ncyc);
        logic [31:0] qb0[$], qb1[$];
        logic [3:0]  qf0[$], qf1[$];
        logic [31:0] rb;
        logic [3:0]  rf;
        logic [31:0] eb;
        logic [3:0]  ef;
        for (int c = 0; c < ncyc + 200; c++) begin
            @(negedge clk);
            out_ready = ($urandom_range(0, 3) != 0);
            if (c < ncyc) begin
                in_valid = ($urandom_range(0, 4) != 0);
                in_bits  = gen_word();
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (out_valid && out_ready) begin
                n_cmp++;
                if (qb0.size() == 0) begin
                    n_bad++;
                    $display("FAIL rnd_unexpected: output bits=%h with no word outstanding", out_bits);
                end else begin
                    eb = qb0.pop_front(); ef = qf0.pop_front();
                    if (out_bits !== eb || out_flags !== ef) begin
                        n_bad++;
                        $display("FAIL rnd_result: bits=%h flags=%h, required bits=%h flags=%h", out_bits, out_flags, eb, ef);
                    end
                    eb = qb1.pop_front(); ef = qf1.pop_front();
                    n_cmp++;
                    if (fl_out_valid !== 1'b1 || fl_out_bits !== eb || fl_out_flags !== ef) begin
                        n_bad++;
                        $display("FAIL rnd_flush_result: valid=%0b bits=%h flags=%h, required 1 bits=%h flags=%h",
                                 fl_out_valid, fl_out_bits, fl_out_flags, eb, ef);
                    end
                end
            end
            if (in_valid && in_ready) begin
                ref_model(in_bits, 1'b0, rb, rf); qb0.push_back(rb); qf0.push_back(rf);
                ref_model(in_bits, 1'b1, rb, rf); qb1.push_back(rb); qf1.push_back(rf);
            end
            if (c >= ncyc && qb0.size() == 0 && !out_valid) break;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        n_cmp++;
        if (qb0.size() != 0) begin
            n_bad++;
            $display("FAIL rnd_drain: %0d words still outstanding, required 0", qb0.size());
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] w  [4];
        logic [31:0] eb [4];
        logic [3:0]  ef [4];
        logic [31:0] held_b;
        logic [3:0]  held_f;
        int sent, got, stall, extra;
        bit was_stalled;
        sent = 0; got = 0; stall = 0; extra = 0; was_stalled = 1'b0;
        held_b = '0; held_f = '0;
        for (int i = 0; i < 4; i++) begin
            w[i] = gen_word();
            ref_model(w[i], 1'b0, eb[i], ef[i]);
        end
        for (int c = 0; c < 40 && got < 4; c++) begin
            @(negedge clk);
            if (was_stalled) begin
                n_cmp++;
                if (out_valid !== 1'b1 || out_bits !== held_b || out_flags !== held_f) begin
                    n_bad++;
                    $display("FAIL b2b_hold: valid=%0b bits=%h flags=%h, required 1 bits=%h flags=%h",
                             out_valid, out_bits, out_flags, held_b, held_f);
                end
            end
            out_ready = (out_valid && stall < 3) ? 1'b0 : 1'b1;
            in_valid  = (sent < 4);
            if (sent < 4) in_bits = w[sent];
            #1;
            was_stalled = out_valid && !out_ready;
            if (was_stalled) begin
                stall++;
                held_b = out_bits; held_f = out_flags;
                n_cmp++;
                if (in_ready !== 1'b0) begin
                    n_bad++;
                    $display("FAIL b2b_in_ready: in_ready=%0b while stalled, required 0", in_ready);
                end
            end
            if (out_valid && out_ready) begin
                n_cmp++;
                if (out_bits !== eb[got] || out_flags !== ef[got]) begin
                    n_bad++;
                    $display("FAIL b2b_order[%0d]: bits=%h flags=%h, required bits=%h flags=%h",
                             got, out_bits, out_flags, eb[got], ef[got]);
                end
                got++;
            end
            if (in_valid && in_ready) sent++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        n_cmp++;
        if (got != 4 || stall != 3) begin
            n_bad++;
            $display("FAIL b2b_count: received=%0d stalls=%0d, required 4 and 3", got, stall);
        end
        repeat (5) begin
            @(negedge clk);
            if (out_valid) extra++;
        end
        n_cmp++;
        if (extra != 0) begin
            n_bad++;
            $display("FAIL b2b_dup: %0d extra outputs, required 0", extra);
        end
    endtask

    task automatic test_reset_midstream();
        int leaked;
        bit seen;
        leaked = 0; seen = 1'b0;
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; in_bits = 64'h4000000000000000;
        @(negedge clk);
        in_bits = 64'hC008000000000000;
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_inflight: out_valid=%0b before reset, required 1", out_valid);
        end
        in_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; out_ready = 1'b1;
        n_cmp++;
        if (out_valid !== 1'b0 || fl_out_valid !== 1'b0 || out_bits !== 32'h0 || out_flags !== 4'h0) begin
            n_bad++;
            $display("FAIL rst_mid: valid=%0b/%0b bits=%h flags=%h, required 0/0 bits=00000000 flags=0",
                     out_valid, fl_out_valid, out_bits, out_flags);
        end
        repeat (6) begin
            @(negedge clk);
            if (out_valid || fl_out_valid) leaked++;
        end
        n_cmp++;
        if (leaked != 0) begin
            n_bad++;
            $display("FAIL rst_leak: %0d dropped-word outputs seen, required 0", leaked);
        end
        in_valid = 1'b1; in_bits = 64'h3FF0000000000000;
        @(negedge clk);
        in_valid = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1'b1;
                n_cmp++;
                if (out_bits !== 32'h3F800000 || out_flags !== 4'h0) begin
                    n_bad++;
                    $display("FAIL rst_after: bits=%h flags=%h, required 3f800000/0", out_bits, out_flags);
                end
            end
        end
        if (!seen) begin
            n_cmp++;
            n_bad++;
            $display("FAIL rst_after_timeout: no output within 10 cycles, required one");
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_random_stream(1500);
        test_back_to_back();
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
